// File: rtl/input_conditioner.sv
// Multi-channel button/switch conditioner: polarity fix, synchroniser, debounce,
// edge pulses, long-press detection and optional auto-repeat per channel.
module input_conditioner #(
  parameter int                  CHANNELS          = 8,
  parameter int                  SYNC_STAGES       = 2,
  parameter int                  DEBOUNCE_CYCLES   = 16,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW_MASK   = '0,
  parameter int                  LONG_PRESS_CYCLES = 1000,
  parameter int                  REPEAT_CYCLES     = 0
) (
  input  logic                Clk,
  input  logic                nReset,
  input  logic [CHANNELS-1:0] RawIn,
  output logic [CHANNELS-1:0] Level,
  output logic [CHANNELS-1:0] Rise,
  output logic [CHANNELS-1:0] Fall,
  output logic [CHANNELS-1:0] LongPress,
  output logic [CHANNELS-1:0] Repeat
);

  localparam int DB_W     = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HOLD_MAX = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DB_W-1:0]        db_cnt;
    logic [HOLD_W-1:0]      hold_cnt;
    logic                   level_q, rise_q, fall_q, long_q;
    logic                   sync_bit, db_hit, flip, level_nxt, held;

    assign sync_bit  = sync_q[SYNC_STAGES-1];
    assign db_hit    = (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    assign flip      = (sync_bit != level_q) && db_hit;
    assign level_nxt = flip ? sync_bit : level_q;
    // True only while the press continues through this edge; a Fall clears
    // the hold/repeat state in the same cycle the Level drops.
    assign held      = level_q && level_nxt;

    // NOTE: every flop, counters included, is reset so that an asserted
    // nReset leaves no stale press state and no spurious pulse on release.
    always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
        sync_q   <= '0;
        db_cnt   <= '0;
        hold_cnt <= '0;
        level_q  <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        long_q   <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values,
        // which is what makes the shift chain and counters behave as registers.
        sync_q <= {sync_q[SYNC_STAGES-2:0], RawIn[i] ^ ACTIVE_LOW_MASK[i]};

        if (sync_bit != level_q)
          db_cnt <= db_hit ? '0 : db_cnt + DB_W'(1);
        else
          db_cnt <= '0;

        level_q <= level_nxt;
        rise_q  <= flip & sync_bit;
        fall_q  <= flip & ~sync_bit;

        if (!held)
          hold_cnt <= '0;
        else if (hold_cnt != '1)
          hold_cnt <= hold_cnt + HOLD_W'(1);

        long_q <= held && (hold_cnt == HOLD_W'(LONG_PRESS_CYCLES - 1));
      end
    end

    assign Level[i]     = level_q;
    assign Rise[i]      = rise_q;
    assign Fall[i]      = fall_q;
    assign LongPress[i] = long_q;

    if (REPEAT_CYCLES > 0) begin : g_rpt
      localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
      logic [RPT_W-1:0] rpt_cnt;
      logic             rpt_q, armed, rpt_hit;

      // Hold saturates at all-ones, which is never below LONG_PRESS_CYCLES,
      // so armed stays set for the rest of the press after LongPress fired.
      assign armed   = held && (hold_cnt >= HOLD_W'(LONG_PRESS_CYCLES));
      assign rpt_hit = (rpt_cnt == RPT_W'(REPEAT_CYCLES - 1));

      always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
          rpt_cnt <= '0;
          rpt_q   <= 1'b0;
        end else begin
          if (!armed || rpt_hit)
            rpt_cnt <= '0;
          else
            rpt_cnt <= rpt_cnt + RPT_W'(1);
          rpt_q <= armed && rpt_hit;
        end
      end

      assign Repeat[i] = rpt_q;
    end else begin : g_no_rpt
      assign Repeat[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed scenarios for input_conditioner; expected output events are queued
// by the stimulus and matched cycle-exactly by an independent monitor.
module tb_input_conditioner;

  localparam int CH = 4;

  typedef struct packed {
    int            cyc;
    logic [CH-1:0] lvl;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] lp;
    logic [CH-1:0] rpt;
  } ev_t;

  logic          Clk = 1'b0;
  logic          nReset;
  logic [CH-1:0] RawIn;
  logic [CH-1:0] Level, Rise, Fall, LongPress, Repeat;

  int  cyc = 0;
  int  tests = 0;
  int  failed = 0;
  ev_t exp_q[$];

  input_conditioner #(
    .CHANNELS          (CH),
    .SYNC_STAGES       (2),
    .DEBOUNCE_CYCLES   (4),
    .ACTIVE_LOW_MASK   (4'b0001),
    .LONG_PRESS_CYCLES (10),
    .REPEAT_CYCLES     (3)
  ) dut (
    .Clk       (Clk),
    .nReset    (nReset),
    .RawIn     (RawIn),
    .Level     (Level),
    .Rise      (Rise),
    .Fall      (Fall),
    .LongPress (LongPress),
    .Repeat    (Repeat)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [CH-1:0] lvl, input logic [CH-1:0] rise,
                      input logic [CH-1:0] fall, input logic [CH-1:0] lp, input logic [CH-1:0] rpt);
    ev_t e;
    e.cyc = c; e.lvl = lvl; e.rise = rise; e.fall = fall; e.lp = lp; e.rpt = rpt;
    exp_q.push_back(e);
  endtask

  task automatic check_quiet(input string name, input logic [CH-1:0] lvl);
    check({name, "_level"}, 32'(Level), 32'(lvl));
    check({name, "_pulses"}, 32'({Rise, Fall, LongPress, Repeat}), 32'h0);
  endtask

  // Monitor: any pulse on any channel must match the next queued event.
  initial begin
    ev_t e;
    forever begin
      @(negedge Clk);
      if (|{Rise, Fall, LongPress, Repeat}) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 32'({Rise, Fall, LongPress, Repeat}), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("event_cycle", 32'(cyc), 32'(e.cyc));
          check("event_outputs", 32'({Level, Rise, Fall, LongPress, Repeat}),
                32'({e.lvl, e.rise, e.fall, e.lp, e.rpt}));
        end
      end
    end
  end

  initial begin
    int c;
    nReset = 1'b0;
    RawIn  = 4'b0001;  // channel 0 is active-low, idle high
    repeat (3) @(negedge Clk);
    check_quiet("in_reset", 4'b0000);
    nReset = 1'b1;
    repeat (10) @(negedge Clk);
    check_quiet("after_reset", 4'b0000);

    // Press ch1, release after 8 cycles: Rise at +6, Fall 6 edges after release.
    @(negedge Clk); c = cyc;
    RawIn[1] = 1'b1;
    push(c + 6, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    repeat (8) @(negedge Clk);
    RawIn[1] = 1'b0;
    push(c + 14, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    repeat (12) @(negedge Clk);
    check_quiet("press_release", 4'b0000);

    // 3-cycle glitch on ch1: no Level change, no pulses.
    @(negedge Clk);
    RawIn[1] = 1'b1;
    repeat (3) @(negedge Clk);
    RawIn[1] = 1'b0;
    repeat (12) @(negedge Clk);
    check_quiet("glitch", 4'b0000);

    // Active-low ch0 held 20 cycles: LongPress at +16, Repeat every 3 after.
    @(negedge Clk); c = cyc;
    RawIn[0] = 1'b0;
    push(c + 6,  4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    push(c + 16, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    push(c + 19, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    push(c + 22, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    push(c + 25, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    push(c + 26, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    repeat (20) @(negedge Clk);
    RawIn[0] = 1'b1;
    repeat (12) @(negedge Clk);
    check_quiet("long_press", 4'b0000);

    // ch2 and ch3 together; ch2 drops after 5 cycles of Level=1, ch3 long-presses.
    @(negedge Clk); c = cyc;
    RawIn[3:2] = 2'b11;
    push(c + 6, 4'b1100, 4'b1100, 4'b0000, 4'b0000, 4'b0000);
    repeat (5) @(negedge Clk);
    RawIn[2] = 1'b0;
    push(c + 11, 4'b1000, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    push(c + 16, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    push(c + 19, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
    push(c + 22, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
    push(c + 25, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
    repeat (15) @(negedge Clk);
    RawIn[3] = 1'b0;
    push(c + 26, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
    repeat (12) @(negedge Clk);
    check_quiet("dual_channel", 4'b0000);

    // Reset mid-press on ch1: immediate clear, no Fall, Rise again after release.
    @(negedge Clk); c = cyc;
    RawIn[1] = 1'b1;
    push(c + 6, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    repeat (9) @(negedge Clk);
    check("pre_reset_level", 32'(Level), 32'h2);
    nReset = 1'b0;
    #1;
    check_quiet("reset_mid_press", 4'b0000);
    repeat (3) @(negedge Clk);
    check_quiet("reset_held", 4'b0000);
    nReset = 1'b1;
    c = cyc;
    push(c + 6, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    repeat (10) @(negedge Clk);
    check("post_reset_level", 32'(Level), 32'h2);
    RawIn[1] = 1'b0;
    c = cyc;
    push(c + 6, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    repeat (12) @(negedge Clk);
    check_quiet("final", 4'b0000);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameters SHALL be:
- CHANNELS, 8: number of independent input channels.
- SYNC_STAGES, 2: synchroniser flops per channel, legal range 2..4.
- DEBOUNCE_CYCLES, 16: consecutive disagreeing samples needed to change Level, 1 or more.
- ACTIVE_LOW_MASK, 0: per-channel bit; 1 inverts that raw input before synchronisation.
- LONG_PRESS_CYCLES, 1000: cycles Level is held high before LongPress fires; must exceed 1.
- REPEAT_CYCLES, 0: auto-repeat period after LongPress; 0 disables repeat.
REQ-002 Ports, clock and reset first:
- Clk  input  1  system clock; all logic on the rising edge.
- nReset  input  1  asynchronous, active-low reset.
- RawIn  input  CHANNELS  asynchronous raw buttons or switches.
- Level  output  CHANNELS  debounced, polarity-corrected level.
- Rise  output  CHANNELS  one-cycle pulse on a 0->1 Level change.
- Fall  output  CHANNELS  one-cycle pulse on a 1->0 Level change.
- LongPress  output  CHANNELS  one-cycle pulse when the hold reaches LONG_PRESS_CYCLES.
- Repeat  output  CHANNELS  one-cycle auto-repeat pulse.
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-004 All outputs SHALL be driven directly from flops.

Function
REQ-005 Each channel SHALL XOR RawIn[i] with ACTIVE_LOW_MASK[i], then pass it through a SYNC_STAGES flop chain.
REQ-006 Each channel SHALL have a debounce counter of width clog2(DEBOUNCE_CYCLES)+1.
REQ-007 Debounce rules per edge:
- If sync != Level and cnt == DEBOUNCE_CYCLES-1: Level <= sync, cnt <= 0.
- Else if sync != Level: cnt <= cnt+1.
- Else: cnt <= 0.
REQ-008 A glitch shorter than DEBOUNCE_CYCLES synchronised samples SHALL NOT change Level and SHALL clear the counter when it ends.
REQ-009 Latency from a stable RawIn change to the Level change SHALL be exactly SYNC_STAGES+DEBOUNCE_CYCLES clock edges.
REQ-010 Rise[i] or Fall[i] SHALL be high for exactly the one cycle in which Level[i] first shows its new value.
REQ-011 Each channel SHALL have a hold counter:
- Cleared to 0 while Level[i]=0.
- Incremented each cycle while Level[i]=1.
- Saturating; wide enough for max(LONG_PRESS_CYCLES, REPEAT_CYCLES).
REQ-012 LongPress[i] SHALL pulse for one cycle when the hold counter reaches LONG_PRESS_CYCLES-1, i.e. in the cycle after LONG_PRESS_CYCLES cycles of Level=1; it SHALL fire at most once per press.
REQ-013 With REPEAT_CYCLES>0, Repeat[i] SHALL pulse every REPEAT_CYCLES cycles after the LongPress pulse while Level[i] stays 1:
- A separate repeat counter restarts at 0 on each pulse.
- Repeat never coincides with LongPress.
REQ-014 With REPEAT_CYCLES=0, Repeat SHALL stay 0.
REQ-015 A Fall SHALL clear the hold and repeat counters in the same cycle; a release before LONG_PRESS_CYCLES SHALL produce no LongPress.
REQ-016 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-017 While nReset=0, all of the following SHALL be 0: synchroniser flops, debounce, hold and repeat counters, Level, Rise, Fall, LongPress and Repeat.
REQ-018 An input that is already active when reset is released SHALL produce a Rise SYNC_STAGES+DEBOUNCE_CYCLES edges after release.
REQ-019 Reset asserted mid-press SHALL clear all state immediately, with no Fall pulse.

Verification
Bench parameters: CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, REPEAT_CYCLES=3, ACTIVE_LOW_MASK=4'b0001.
REQ-020 Scenario: RawIn[1] 0->1 held -> Level[1]=1 and Rise[1] one-cycle pulse at edge 6.
REQ-021 Scenario: RawIn[1] 3-cycle high glitch -> Level[1] stays 0; no Rise or Fall.
REQ-022 Scenario: RawIn[0] driven 1->0 (active-low press) and held 20 cycles -> Rise[0] at edge 6, LongPress[0] at edge 16, Repeat[0] at edges 19 and 22.
REQ-023 Scenario: RawIn[2] and RawIn[3] asserted in the same cycle -> Rise[2] and Rise[3] pulse in the same cycle.
REQ-024 Scenario: RawIn[2] released after 5 cycles of Level=1 -> Fall[2] pulses once, with no LongPress.
REQ-025 Scenario: nReset pulled low during a press with Level[1]=1 -> all outputs 0 at once with no Fall; after release with the input still held, Rise[1] at edge 6.
